mem_arbiter: RTL and testbench

//   Byte-wide RAM arbiter/sequencer shared by icache and dcache. Issues at most one byte op per

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arb_stats.sv | 42 ++++
 rtl/mem_arbiter.sv | 109 ++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the byte-wide RAM arbiter.
// Optional performance counters are enabled with MEM_ARB_STATS_EN.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 18;

  // Address bits [ADDR_W-1:ADDR_W-2] equal to this value select the IO (UART) space.
  localparam logic [1:0] IO_ADDR_HI = 2'b11;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_ICACHE,
    OWN_DCACHE
  } owner_t;

endpackage

// File: rtl/mem_arb_stats.sv
// Saturating performance counters for the RAM arbiter.
// Instantiated only when MEM_ARB_STATS_EN is defined.
module mem_arb_stats #(
  parameter int unsigned STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_dcache_issue,
  input  logic              i_icache_issue,
  input  logic              i_icache_stall,
  output logic [STAT_W-1:0] o_dcache_ops,
  output logic [STAT_W-1:0] o_icache_ops,
  output logic [STAT_W-1:0] o_icache_stall
);

  localparam logic [STAT_W-1:0] One = {{(STAT_W-1){1'b0}}, 1'b1};

  logic [STAT_W-1:0] r_dcache_ops;
  logic [STAT_W-1:0] r_icache_ops;
  logic [STAT_W-1:0] r_icache_stall;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] val, input logic en);
    return (en && (val != '1)) ? val + One : val;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dcache_ops   <= '0;
      r_icache_ops   <= '0;
      r_icache_stall <= '0;
    end else begin
      r_dcache_ops   <= sat_inc(r_dcache_ops, i_dcache_issue);
      r_icache_ops   <= sat_inc(r_icache_ops, i_icache_issue);
      r_icache_stall <= sat_inc(r_icache_stall, i_icache_stall);
    end
  end

  assign o_dcache_ops   = r_dcache_ops;
  assign o_icache_ops   = r_icache_ops;
  assign o_icache_stall = r_icache_stall;

endmodule

// File: rtl/mem_arbiter.sv
// Byte-wide RAM arbiter shared by icache and dcache; dcache wins, IO writes wait on buffer space.
// Define MEM_ARB_STATS_EN to add saturating stat_* performance counters.
module mem_arbiter #(
  parameter int unsigned ADDR_W = mem_arb_pkg::ADDR_W
`ifdef MEM_ARB_STATS_EN
  , parameter int unsigned STAT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy_in,
  input  logic              icache_get_en,
  input  logic [ADDR_W-1:0] icache_addr,
  output logic              icache_out_en,
  output logic [7:0]        icache_content,
  input  logic              dcache_get_en,
  input  logic              dcache_write_mode,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic [7:0]        dcache_data,
  output logic              dcache_out_en,
  output logic [7:0]        dcache_content,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
`ifdef MEM_ARB_STATS_EN
  , output logic [STAT_W-1:0] stat_dcache_ops
  , output logic [STAT_W-1:0] stat_icache_ops
  , output logic [STAT_W-1:0] stat_icache_stall
`endif
);

  import mem_arb_pkg::*;

  logic              w_io_blocked;
  logic              w_cmpl;
  owner_t            w_owner;
  owner_t            r_pend;
  logic [ADDR_W-1:0] r_last_addr;

  assign w_io_blocked = dcache_write_mode && (dcache_addr[ADDR_W-1 -: 2] == IO_ADDR_HI)
                        && io_buffer_full;

  always_comb begin
    w_owner = OWN_NONE;
    if (rdy_in && !rst) begin
      if (dcache_get_en && !w_io_blocked) begin
        w_owner = OWN_DCACHE;
      end else if (icache_get_en) begin
        w_owner = OWN_ICACHE;
      end
    end
  end

  // Idle address stays on the last issued byte so mem_din remains valid across a freeze.
  always_comb begin
    mem_a    = r_last_addr;
    mem_wr   = 1'b0;
    mem_dout = '0;
    unique case (w_owner)
      OWN_DCACHE: begin
        mem_a    = dcache_addr;
        mem_wr   = dcache_write_mode;
        mem_dout = dcache_write_mode ? dcache_data : 8'h00;
      end
      OWN_ICACHE: mem_a = icache_addr;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend      <= OWN_NONE;
      r_last_addr <= '0;
    end else if (rdy_in) begin
      r_pend <= w_owner;
      if (w_owner != OWN_NONE) begin
        r_last_addr <= mem_a;
      end
    end
  end

  // A byte caught by reset is dropped rather than completed.
  assign w_cmpl = rdy_in && !rst;

  always_comb begin
    icache_out_en  = w_cmpl && (r_pend == OWN_ICACHE);
    dcache_out_en  = w_cmpl && (r_pend == OWN_DCACHE);
    icache_content = icache_out_en ? mem_din : 8'h00;
    dcache_content = dcache_out_en ? mem_din : 8'h00;
  end

`ifdef MEM_ARB_STATS_EN
  mem_arb_stats #(
    .STAT_W(STAT_W)
  ) u_stats (
    .clk           (clk),
    .rst           (rst),
    .i_dcache_issue(w_owner == OWN_DCACHE),
    .i_icache_issue(w_owner == OWN_ICACHE),
    .i_icache_stall(icache_get_en && (w_owner == OWN_DCACHE)),
    .o_dcache_ops  (stat_dcache_ops),
    .o_icache_ops  (stat_icache_ops),
    .o_icache_stall(stat_icache_stall)
  );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 1-cycle-latency RAM model.
// Counter checks are compiled in when MEM_ARB_STATS_EN is defined.
module tb_mem_arbiter;

  localparam int unsigned AW = 18;
  localparam int unsigned SW = 32;

  logic          clk;
  logic          rst;
  logic          rdy_in;
  logic          icache_get_en;
  logic [AW-1:0] icache_addr;
  logic          icache_out_en;
  logic [7:0]    icache_content;
  logic          dcache_get_en;
  logic          dcache_write_mode;
  logic [AW-1:0] dcache_addr;
  logic [7:0]    dcache_data;
  logic          dcache_out_en;
  logic [7:0]    dcache_content;
  logic          io_buffer_full;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout;
  logic [AW-1:0] mem_a;
  logic          mem_wr;
`ifdef MEM_ARB_STATS_EN
  logic [SW-1:0] stat_dcache_ops;
  logic [SW-1:0] stat_icache_ops;
  logic [SW-1:0] stat_icache_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(
    .ADDR_W(AW)
`ifdef MEM_ARB_STATS_EN
    , .STAT_W(SW)
`endif
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .rdy_in           (rdy_in),
    .icache_get_en    (icache_get_en),
    .icache_addr      (icache_addr),
    .icache_out_en    (icache_out_en),
    .icache_content   (icache_content),
    .dcache_get_en    (dcache_get_en),
    .dcache_write_mode(dcache_write_mode),
    .dcache_addr      (dcache_addr),
    .dcache_data      (dcache_data),
    .dcache_out_en    (dcache_out_en),
    .dcache_content   (dcache_content),
    .io_buffer_full   (io_buffer_full),
    .mem_din          (mem_din),
    .mem_dout         (mem_dout),
    .mem_a            (mem_a),
    .mem_wr           (mem_wr)
`ifdef MEM_ARB_STATS_EN
    , .stat_dcache_ops  (stat_dcache_ops)
    , .stat_icache_ops  (stat_icache_ops)
    , .stat_icache_stall(stat_icache_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: unwritten bytes come from a fixed preload table.
  logic [7:0] ram     [0:(1<<AW)-1];
  bit         written [0:(1<<AW)-1];

  function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
    case (a)
      18'h00010: return 8'h11;
      18'h00011: return 8'h22;
      18'h00012: return 8'h33;
      18'h00013: return 8'h44;
      18'h00100: return 8'hA5;
      18'h00200: return 8'h5C;
      default:   return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    mem_din <= written[mem_a] ? ram[mem_a] : init_byte(mem_a);
    if (mem_wr) begin
      ram[mem_a]     <= mem_dout;
      written[mem_a] <= 1'b1;
    end
  end

  typedef struct {
    logic          rdy;
    logic          ig;
    logic [AW-1:0] ia;
    logic          dg;
    logic          dw;
    logic [AW-1:0] da;
    logic [7:0]    dd;
    logic          iof;
    logic [AW-1:0] ma;
    logic          wr;
    logic [7:0]    dout;
    logic          ioe;
    logic [7:0]    ic;
    logic          doe;
    logic [7:0]    dc;
    logic          dcx;  // dcache_content is don't-care (write completion)
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic rdy, input logic ig, input logic [AW-1:0] ia,
                             input logic dg, input logic dw, input logic [AW-1:0] da,
                             input logic [7:0] dd, input logic iof, input logic [AW-1:0] ma,
                             input logic wr, input logic [7:0] dout, input logic ioe,
                             input logic [7:0] ic, input logic doe, input logic [7:0] dc,
                             input logic dcx);
    vec_t r;
    r.rdy = rdy; r.ig = ig; r.ia = ia; r.dg = dg; r.dw = dw; r.da = da; r.dd = dd;
    r.iof = iof; r.ma = ma; r.wr = wr; r.dout = dout; r.ioe = ioe; r.ic = ic;
    r.doe = doe; r.dc = dc; r.dcx = dcx;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ig, input logic [AW-1:0] ia, input logic dg,
                       input logic dw, input logic [AW-1:0] da, input logic [7:0] dd,
                       input logic iof);
    rdy_in = r; icache_get_en = ig; icache_addr = ia; dcache_get_en = dg;
    dcache_write_mode = dw; dcache_addr = da; dcache_data = dd; io_buffer_full = iof;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " mem_a"}, 32'(mem_a), 32'h0);
    chk({tag, " mem_wr"}, 32'(mem_wr), 32'h0);
    chk({tag, " mem_dout"}, 32'(mem_dout), 32'h0);
    chk({tag, " i_out_en"}, 32'(icache_out_en), 32'h0);
    chk({tag, " i_content"}, 32'(icache_content), 32'h0);
    chk({tag, " d_out_en"}, 32'(dcache_out_en), 32'h0);
    chk({tag, " d_content"}, 32'(dcache_content), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0);

    // rdy ig  ia        dg dw da         dd     iof | ma         wr dout   ioe ic     doe dc     x
    // back-to-back icache reads
    vecs.push_back(v(1, 1, 18'h10,  0, 0, 0,        0,     0, 18'h10,    0, 0,     0, 0,     0, 0,     0));
    vecs.push_back(v(1, 1, 18'h11,  0, 0, 0,        0,     0, 18'h11,    0, 0,     1, 8'h11, 0, 0,     0));
    vecs.push_back(v(1, 1, 18'h12,  0, 0, 0,        0,     0, 18'h12,    0, 0,     1, 8'h22, 0, 0,     0));
    vecs.push_back(v(1, 1, 18'h13,  0, 0, 0,        0,     0, 18'h13,    0, 0,     1, 8'h33, 0, 0,     0));
    vecs.push_back(v(1, 0, 0,       0, 0, 0,        0,     0, 18'h13,    0, 0,     1, 8'h44, 0, 0,     0));
    vecs.push_back(v(1, 0, 0,       0, 0, 0,        0,     0, 18'h13,    0, 0,     0, 0,     0, 0,     0));
    // simultaneous requests: dcache first, icache next cycle
    vecs.push_back(v(1, 1, 18'h200, 1, 0, 18'h100,  0,     0, 18'h100,   0, 0,     0, 0,     0, 0,     0));
    vecs.push_back(v(1, 1, 18'h200, 0, 0, 0,        0,     0, 18'h200,   0, 0,     0, 0,     1, 8'hA5, 0));
    vecs.push_back(v(1, 0, 0,       0, 0, 0,        0,     0, 18'h200,   0, 0,     1, 8'h5C, 0, 0,     0));
    // IO write blocked while buffer full; icache served meanwhile
    vecs.push_back(v(1, 1, 18'h10,  1, 1, 18'h30000, 8'h41, 1, 18'h10,   0, 0,     0, 0,     0, 0,     0));
    vecs.push_back(v(1, 1, 18'h11,  1, 1, 18'h30000, 8'h41, 1, 18'h11,   0, 0,     1, 8'h11, 0, 0,     0));
    vecs.push_back(v(1, 0, 0,       1, 1, 18'h30000, 8'h41, 1, 18'h11,   0, 0,     1, 8'h22, 0, 0,     0));
    vecs.push_back(v(1, 0, 0,       1, 1, 18'h30000, 8'h41, 0, 18'h30000, 1, 8'h41, 0, 0,     0, 0,     0));
    vecs.push_back(v(1, 0, 0,       0, 0, 0,        0,     0, 18'h30000, 0, 0,     0, 0,     1, 0,     1));
    // rdy_in freeze with a dcache read in flight
    vecs.push_back(v(1, 0, 0,       1, 0, 18'h100,  0,     0, 18'h100,   0, 0,     0, 0,     0, 0,     0));
    vecs.push_back(v(0, 0, 0,       1, 0, 18'h100,  0,     0, 18'h100,   0, 0,     0, 0,     0, 0,     0));
    vecs.push_back(v(0, 1, 18'h12,  1, 0, 18'h100,  0,     0, 18'h100,   0, 0,     0, 0,     0, 0,     0));
    vecs.push_back(v(1, 1, 18'h12,  0, 0, 0,        0,     0, 18'h12,    0, 0,     0, 0,     1, 8'hA5, 0));
    vecs.push_back(v(1, 0, 0,       0, 0, 0,        0,     0, 18'h12,    0, 0,     1, 8'h33, 0, 0,     0));
    // read back the IO-space byte written above
    vecs.push_back(v(1, 0, 0,       1, 0, 18'h30000, 0,    0, 18'h30000, 0, 0,     0, 0,     0, 0,     0));
    vecs.push_back(v(1, 0, 0,       0, 0, 0,        0,     0, 18'h30000, 0, 0,     0, 0,     1, 8'h41, 0));
    // non-IO write is not gated by io_buffer_full
    vecs.push_back(v(1, 0, 0,       1, 1, 18'h20000, 8'h77, 1, 18'h20000, 1, 8'h77, 0, 0,     0, 0,     0));
    vecs.push_back(v(1, 0, 0,       0, 0, 0,        0,     0, 18'h20000, 0, 0,     0, 0,     1, 0,     1));
    // write presented during freeze must not strobe
    vecs.push_back(v(0, 0, 0,       1, 1, 18'h20001, 8'h66, 0, 18'h20000, 0, 0,     0, 0,     0, 0,     0));
    vecs.push_back(v(1, 0, 0,       1, 1, 18'h20001, 8'h66, 0, 18'h20001, 1, 8'h66, 0, 0,     0, 0,     0));
    vecs.push_back(v(1, 0, 0,       0, 0, 0,        0,     0, 18'h20001, 0, 0,     0, 0,     1, 0,     1));

    next_cycle();
    next_cycle();
    rst = 1'b0;
    #1;
    chk_idle("reset");
`ifdef MEM_ARB_STATS_EN
    chk("reset stat_d", stat_dcache_ops, 32'd0);
    chk("reset stat_i", stat_icache_ops, 32'd0);
    chk("reset stat_s", stat_icache_stall, 32'd0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      next_cycle();
      drive(vecs[i].rdy, vecs[i].ig, vecs[i].ia, vecs[i].dg, vecs[i].dw, vecs[i].da,
            vecs[i].dd, vecs[i].iof);
      #1;
      chk($sformatf("v%0d mem_a", i), 32'(mem_a), 32'(vecs[i].ma));
      chk($sformatf("v%0d mem_wr", i), 32'(mem_wr), 32'(vecs[i].wr));
      chk($sformatf("v%0d mem_dout", i), 32'(mem_dout), 32'(vecs[i].dout));
      chk($sformatf("v%0d i_out_en", i), 32'(icache_out_en), 32'(vecs[i].ioe));
      chk($sformatf("v%0d i_content", i), 32'(icache_content), 32'(vecs[i].ic));
      chk($sformatf("v%0d d_out_en", i), 32'(dcache_out_en), 32'(vecs[i].doe));
      if (!vecs[i].dcx) begin
        chk($sformatf("v%0d d_content", i), 32'(dcache_content), 32'(vecs[i].dc));
      end
    end

    // Reset with an icache byte in flight drops it; a write presented during reset never strobes.
    next_cycle();
    drive(1, 1, 18'h13, 0, 0, 0, 0, 0);
    #1;
    chk("rstmid issue mem_a", 32'(mem_a), 32'h13);
    next_cycle();
    rst = 1'b1;
    drive(1, 0, 0, 1, 1, 18'h40, 8'hFF, 0);
    #1;
    chk("rstmid mem_wr", 32'(mem_wr), 32'h0);
    chk("rstmid i_out_en", 32'(icache_out_en), 32'h0);
    chk("rstmid d_out_en", 32'(dcache_out_en), 32'h0);
    next_cycle();
    rst = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk_idle("postrst");
    next_cycle();
    chk("postrst2 i_out_en", 32'(icache_out_en), 32'h0);

`ifdef MEM_ARB_STATS_EN
    chk("postrst stat_d", stat_dcache_ops, 32'd0);
    chk("postrst stat_i", stat_icache_ops, 32'd0);
    chk("postrst stat_s", stat_icache_stall, 32'd0);
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      drive(1, 1, 18'h200, 1, 0, 18'h100, 0, 0);
      #1;
      chk($sformatf("stats%0d mem_a", k), 32'(mem_a), 32'h100);
      next_cycle();
      drive(1, 1, 18'h200, 0, 0, 0, 0, 0);
      next_cycle();
      drive(1, 0, 0, 0, 0, 0, 0, 0);
    end
    next_cycle();
    chk("stat_dcache_ops", stat_dcache_ops, 32'd10);
    chk("stat_icache_ops", stat_icache_ops, 32'd10);
    chk("stat_icache_stall", stat_icache_stall, 32'd10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
